// File: rtl/allocate_writeback_arbiter_pkg.sv
// allocate_writeback_arbiter_pkg: shared writeback parameters and types.
package allocate_writeback_arbiter_pkg;
    localparam int FIFO_DEPTH_DEF   = 4;
    localparam int STARVE_LIMIT_DEF = 3;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_ALU  = 2'd1,
        GRANT_LSU  = 2'd2
    } grant_e;
endpackage

// File: rtl/allocate_writeback_fifo.sv
// allocate_writeback_fifo: per-source result queue; a full queue refuses pushes even when popped.
module allocate_writeback_fifo
    import allocate_writeback_arbiter_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
)(
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic          i_pop,
    input  wb_entry_t     i_data,
    output wb_entry_t     o_data,
    output logic          o_empty,
    output logic          o_full,
    output logic [CW-1:0] o_count
);
    wb_entry_t     r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_data  = r_mem[r_rd];
    assign w_push  = i_push && !o_full && !i_clear;
    assign w_pop   = i_pop && !o_empty && !i_clear;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= (r_wr == PW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
            if (w_pop)  r_rd <= (r_rd == PW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/allocate_writeback_arbiter.sv
// allocate_writeback_arbiter: merges queued ALU and LSU results onto one register-file write port,
// favouring the ALU but forcing an LSU grant after repeated losses or when the LSU queue is full.
module allocate_writeback_arbiter
    import allocate_writeback_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    localparam int CW = $clog2(FIFO_DEPTH + 1)
)(
    input  logic        iCLOCK,
    input  logic        inRESET,
    input  logic        iRESET_SYNC,
    input  logic        iALU_VALID,
    input  logic [4:0]  iALU_ADDR,
    input  logic [31:0] iALU_DATA,
    output logic        oALU_BUSY,
    input  logic        iLSU_VALID,
    input  logic [4:0]  iLSU_ADDR,
    input  logic [31:0] iLSU_DATA,
    output logic        oLSU_BUSY,
    output logic        oWR_VALID,
    output logic [4:0]  oWR_ADDR,
    output logic [31:0] oWR_DATA
);
    wb_entry_t     w_alu_head;
    wb_entry_t     w_lsu_head;
    wb_entry_t     w_head;
    logic          w_alu_empty;
    logic          w_alu_full;
    logic          w_lsu_empty;
    logic          w_lsu_full;
    logic [CW-1:0] w_alu_count;
    logic [CW-1:0] w_lsu_count;
    logic          w_starved;
    grant_e        w_grant;
    logic [1:0]    r_starve;
    logic          r_wr_valid;
    wb_entry_t     r_wr;

    allocate_writeback_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .i_clk   (iCLOCK),
        .i_rst_n (inRESET),
        .i_clear (iRESET_SYNC),
        .i_push  (iALU_VALID),
        .i_pop   (w_grant == GRANT_ALU),
        .i_data  ({iALU_ADDR, iALU_DATA}),
        .o_data  (w_alu_head),
        .o_empty (w_alu_empty),
        .o_full  (w_alu_full),
        .o_count (w_alu_count)
    );

    allocate_writeback_fifo #(.DEPTH(FIFO_DEPTH)) u_lsu_fifo (
        .i_clk   (iCLOCK),
        .i_rst_n (inRESET),
        .i_clear (iRESET_SYNC),
        .i_push  (iLSU_VALID),
        .i_pop   (w_grant == GRANT_LSU),
        .i_data  ({iLSU_ADDR, iLSU_DATA}),
        .o_data  (w_lsu_head),
        .o_empty (w_lsu_empty),
        .o_full  (w_lsu_full),
        .o_count (w_lsu_count)
    );

    assign oALU_BUSY = (w_alu_count == CW'(FIFO_DEPTH));
    assign oLSU_BUSY = (w_lsu_count == CW'(FIFO_DEPTH));
    assign w_starved = (r_starve == 2'(STARVE_LIMIT));

    // ALU wins contention unless the LSU has lost too often or its queue is backing up.
    always_comb begin
        w_grant = GRANT_NONE;
        if (!w_alu_empty && (w_lsu_empty || !(w_starved || w_lsu_full)))
            w_grant = GRANT_ALU;
        else if (!w_lsu_empty)
            w_grant = GRANT_LSU;
        w_head = (w_grant == GRANT_LSU) ? w_lsu_head : w_alu_head;
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_starve   <= '0;
            r_wr_valid <= 1'b0;
            r_wr       <= '0;
        end else if (iRESET_SYNC) begin
            r_starve   <= '0;
            r_wr_valid <= 1'b0;
            r_wr       <= '0;
        end else begin
            r_wr_valid <= (w_grant != GRANT_NONE);
            if (w_grant != GRANT_NONE) r_wr <= w_head;
            if (w_grant == GRANT_LSU)
                r_starve <= '0;
            else if (w_grant == GRANT_ALU && !w_lsu_empty && !w_starved)
                r_starve <= r_starve + 2'd1;
        end
    end

    assign oWR_VALID = r_wr_valid;
    assign oWR_ADDR  = r_wr.addr;
    assign oWR_DATA  = r_wr.data;
endmodule

// File: tb/tb_allocate_writeback_arbiter.sv
// tb_allocate_writeback_arbiter: random and directed stimulus checked against a queue-based model
// of the writeback arbitration rules.
module tb_allocate_writeback_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic        iCLOCK = 1'b0;
    logic        inRESET = 1'b0;
    logic        iRESET_SYNC = 1'b0;
    logic        iALU_VALID = 1'b0;
    logic [4:0]  iALU_ADDR = '0;
    logic [31:0] iALU_DATA = '0;
    logic        oALU_BUSY;
    logic        iLSU_VALID = 1'b0;
    logic [4:0]  iLSU_ADDR = '0;
    logic [31:0] iLSU_DATA = '0;
    logic        oLSU_BUSY;
    logic        oWR_VALID;
    logic [4:0]  oWR_ADDR;
    logic [31:0] oWR_DATA;

    int vectors = 0;
    int miscompares = 0;

    logic [36:0] qa[$];
    logic [36:0] ql[$];
    int          starve = 0;
    logic        m_valid = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    int          accepts = 0;
    int          dut_writes = 0;
    int          dut_lsu_writes = 0;

    always #5 iCLOCK = ~iCLOCK;

    allocate_writeback_arbiter dut (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iRESET_SYNC (iRESET_SYNC),
        .iALU_VALID  (iALU_VALID),
        .iALU_ADDR   (iALU_ADDR),
        .iALU_DATA   (iALU_DATA),
        .oALU_BUSY   (oALU_BUSY),
        .iLSU_VALID  (iLSU_VALID),
        .iLSU_ADDR   (iLSU_ADDR),
        .iLSU_DATA   (iLSU_DATA),
        .oLSU_BUSY   (oLSU_BUSY),
        .oWR_VALID   (oWR_VALID),
        .oWR_ADDR    (oWR_ADDR),
        .oWR_DATA    (oWR_DATA)
    );

    task automatic model_clear();
        qa.delete();
        ql.delete();
        starve  = 0;
        m_valid = 1'b0;
        m_addr  = '0;
        m_data  = '0;
    endtask

    task automatic drive(input logic va, input logic [4:0] aa, input logic [31:0] da,
                         input logic vl, input logic [4:0] al, input logic [31:0] dl);
        iALU_VALID = va; iALU_ADDR = aa; iALU_DATA = da;
        iLSU_VALID = vl; iLSU_ADDR = al; iLSU_DATA = dl;
    endtask

    // Advance one clock edge: apply the arbitration rules to the model, then compare.
    task automatic tick();
        logic [36:0] e;
        int na, nl;
        bit ga, gl, pa, pl;
        logic [1:0] exp_busy;
        na = qa.size();
        nl = ql.size();
        pa = iALU_VALID && na < DEPTH;
        pl = iLSU_VALID && nl < DEPTH;
        e  = '0;
        if (iRESET_SYNC) begin
            model_clear();
        end else begin
            gl = nl > 0 && (na == 0 || starve == LIMIT || nl == DEPTH);
            ga = na > 0 && !gl;
            m_valid = ga || gl;
            if (ga) begin
                e = qa.pop_front();
                if (nl > 0) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
            end
            if (gl) begin
                e = ql.pop_front();
                starve = 0;
            end
            if (m_valid) begin
                m_addr = e[36:32];
                m_data = e[31:0];
            end
            if (pa) begin qa.push_back({iALU_ADDR, iALU_DATA}); accepts++; end
            if (pl) begin ql.push_back({iLSU_ADDR, iLSU_DATA}); accepts++; end
        end
        @(posedge iCLOCK);
        #1;
        if (oWR_VALID === 1'b1) begin
            dut_writes++;
            if (oWR_ADDR[4]) dut_lsu_writes++;
        end
        vectors++;
        if (oWR_VALID !== m_valid || oWR_ADDR !== m_addr || oWR_DATA !== m_data) begin
            miscompares++;
            $display("FAIL wr_port at %0t: got v=%b a=%0d d=%h, expected v=%b a=%0d d=%h",
                     $time, oWR_VALID, oWR_ADDR, oWR_DATA, m_valid, m_addr, m_data);
        end
        exp_busy = {qa.size() == DEPTH, ql.size() == DEPTH};
        vectors++;
        if ({oALU_BUSY, oLSU_BUSY} !== exp_busy) begin
            miscompares++;
            $display("FAIL busy at %0t: got alu=%b lsu=%b, expected alu=%b lsu=%b",
                     $time, oALU_BUSY, oLSU_BUSY, exp_busy[1], exp_busy[0]);
        end
    endtask

    task automatic drain();
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2 * DEPTH + 4; i++) tick();
    endtask

    task automatic sync_clear();
        iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        vectors++;
        if (oWR_VALID !== 1'b0 || oWR_ADDR !== 5'd0 || oWR_DATA !== 32'd0 ||
            oALU_BUSY !== 1'b0 || oLSU_BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got v=%b a=%0d d=%h busy=%b%b, expected all zero",
                     oWR_VALID, oWR_ADDR, oWR_DATA, oALU_BUSY, oLSU_BUSY);
        end
        @(posedge iCLOCK);
        #3;
        inRESET = 1'b1;
        @(posedge iCLOCK);
        #1;
        model_clear();
    endtask

    task automatic test_single_write();
        drive(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        tick();
        vectors++;
        if (oWR_VALID !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early: got v=%b, expected 0", oWR_VALID);
        end
        drive(0, 0, 0, 0, 0, 0);
        tick();
        vectors++;
        if (oWR_VALID !== 1'b1 || oWR_ADDR !== 5'd5 || oWR_DATA !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL single_write: got v=%b a=%0d d=%h, expected v=1 a=5 d=deadbeef",
                     oWR_VALID, oWR_ADDR, oWR_DATA);
        end
        tick();
        vectors++;
        if (oWR_VALID !== 1'b0 || oWR_DATA !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL single_once: got v=%b d=%h, expected v=0 d=deadbeef held",
                     oWR_VALID, oWR_DATA);
        end
    endtask

    task automatic test_contention();
        int acc0, wr0;
        sync_clear();
        acc0 = accepts;
        wr0  = dut_writes;
        for (int i = 0; i < 24; i++) begin
            drive(1, 5'($urandom_range(0, 15)), $urandom, 1, 5'($urandom_range(16, 31)), $urandom);
            tick();
        end
        drain();
        vectors++;
        if (dut_writes - wr0 !== accepts - acc0) begin
            miscompares++;
            $display("FAIL contention_count: got %0d writes, expected %0d",
                     dut_writes - wr0, accepts - acc0);
        end
    endtask

    task automatic test_lsu_full();
        int lw0;
        sync_clear();
        lw0 = dut_lsu_writes;
        for (int i = 0; i < 5; i++) begin
            drive(1, 5'($urandom_range(0, 15)), $urandom, 1, 5'(16 + i), $urandom);
            tick();
            if (i == 3) begin
                vectors++;
                if (oLSU_BUSY !== 1'b1) begin
                    miscompares++;
                    $display("FAIL lsu_busy_after_4: got %b, expected 1", oLSU_BUSY);
                end
            end
        end
        vectors++;
        if (oWR_VALID !== 1'b1 || oWR_ADDR !== 5'd16) begin
            miscompares++;
            $display("FAIL lsu_forced: got v=%b a=%0d, expected v=1 a=16", oWR_VALID, oWR_ADDR);
        end
        for (int i = 0; i < 6; i++) begin
            drive(1, 5'($urandom_range(0, 15)), $urandom, 0, 0, 0);
            tick();
        end
        drain();
        vectors++;
        if (dut_lsu_writes - lw0 !== 4) begin
            miscompares++;
            $display("FAIL lsu_fifth_ignored: got %0d lsu writes, expected 4",
                     dut_lsu_writes - lw0);
        end
    endtask

    task automatic test_sync_reset();
        int wr0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 5'($urandom_range(0, 15)), $urandom, 1, 5'($urandom_range(16, 31)), $urandom);
            tick();
        end
        iRESET_SYNC = 1'b1;
        tick();
        iRESET_SYNC = 1'b0;
        vectors++;
        if (oWR_VALID !== 1'b0 || oALU_BUSY !== 1'b0 || oLSU_BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL sync_reset: got v=%b busy=%b%b, expected 0 00",
                     oWR_VALID, oALU_BUSY, oLSU_BUSY);
        end
        wr0 = dut_writes;
        drain();
        vectors++;
        if (dut_writes !== wr0) begin
            miscompares++;
            $display("FAIL sync_stale: got %0d writes after clear, expected 0", dut_writes - wr0);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, 5'($urandom_range(0, 15)), $urandom, 1, 5'($urandom_range(16, 31)), $urandom);
            tick();
        end
        #2;
        inRESET = 1'b0;
        #1;
        vectors++;
        if (oWR_VALID !== 1'b0 || oWR_ADDR !== 5'd0 || oWR_DATA !== 32'd0 ||
            oALU_BUSY !== 1'b0 || oLSU_BUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: got v=%b a=%0d d=%h busy=%b%b, expected all zero",
                     oWR_VALID, oWR_ADDR, oWR_DATA, oALU_BUSY, oLSU_BUSY);
        end
        model_clear();
        drive(0, 0, 0, 0, 0, 0);
        @(posedge iCLOCK);
        #3;
        inRESET = 1'b1;
        @(posedge iCLOCK);
        #1;
        drive(0, 0, 0, 1, 5'd21, 32'hCAFE0001);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        vectors++;
        if (oWR_VALID !== 1'b1 || oWR_ADDR !== 5'd21 || oWR_DATA !== 32'hCAFE0001) begin
            miscompares++;
            $display("FAIL async_latency: got v=%b a=%0d d=%h, expected v=1 a=21 d=cafe0001",
                     oWR_VALID, oWR_ADDR, oWR_DATA);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            iRESET_SYNC = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 2) != 0, 5'($urandom), $urandom,
                  $urandom_range(0, 2) != 0, 5'($urandom), $urandom);
            tick();
        end
        iRESET_SYNC = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_lsu_full();
        test_sync_reset();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
